fifo_sync_ctrl: RTL and testbench
=================================

Name: fifo_sync_ctrl

Overview:
- Single-clock FIFO with integrated storage, pointer control and status flags. Successor to the bare FIFO memory array.
- Adds a configurable read mode (first-word-fall-through or registered), a fill-level output, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Used as the standard buffering element between same-clock producers and consumers (UART paths, stream adapters).

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- AW, 4, address width, equal to log2(DEPTH); pointers are AW+1 bits wide, the MSB being the wrap bit.
- FWFT, 1, 1 = first-word-fall-through, 0 = registered read with 1-cycle latency.
- AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_LEVEL.
- AE_LEVEL, 2, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL.

Ports:
- CLK  in  1  single clock; all logic is rising-edge.
- RSTN  in  1  asynchronous active-low reset.
- W_EN  in  1  write request.
- W_DI  in  WIDTH  write data.
- R_EN  in  1  read request / pop.
- R_DO  out  WIDTH  read data.
- R_VALID  out  1  R_DO holds valid data.
- FULL  out  1  no free entries.
- EMPTY  out  1  no stored entries.
- ALMOST_FULL  out  1  level at or above AF_LEVEL.
- ALMOST_EMPTY  out  1  level at or below AE_LEVEL.
- COUNT  out  AW+1  current occupancy, 0..DEPTH.
- OVF  out  1  sticky: write attempted while FULL.
- UDF  out  1  sticky: read attempted while EMPTY.
- ERR_CLR  in  1  synchronous clear of OVF and UDF.

Behaviour:
- Reset (async on RSTN low, released synchronously by the design environment):
  - W_PTR = 0, R_PTR = 0, COUNT = 0.
  - EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0.
  - OVF = 0, UDF = 0, R_VALID = 0, R_DO = 0.
  - Memory contents are not reset.
- Write acceptance: wr_ok = W_EN & !FULL. On wr_ok, mem[W_PTR[AW-1:0]] <= W_DI and W_PTR increments, wrapping naturally at 2^(AW+1).
- Read acceptance: rd_ok = R_EN & !EMPTY. On rd_ok, R_PTR increments.
- Status flags:
  - FULL = (W_PTR[AW] != R_PTR[AW]) & (W_PTR[AW-1:0] == R_PTR[AW-1:0]).
  - EMPTY = (W_PTR == R_PTR).
  - FULL and EMPTY are registered, or derived from registered pointers; no combinational path from W_EN or R_EN.
  - COUNT = W_PTR - R_PTR, computed modulo 2^(AW+1). ALMOST_FULL and ALMOST_EMPTY are derived from COUNT.
- FWFT=1 mode:
  - R_DO = mem[R_PTR[AW-1:0]] (combinational array read) and R_VALID = !EMPTY.
  - R_EN pops the current word; the next word appears on R_DO in the same cycle as the pointer update.
- FWFT=0 mode:
  - On rd_ok, R_DO <= mem[R_PTR[AW-1:0]] and R_VALID <= 1 on the next edge.
  - R_VALID <= 0 when there is no rd_ok. R_DO holds its last value.
- Simultaneous read and write:
  - Not full and not empty: both accepted, COUNT unchanged.
  - When EMPTY: only the write is accepted; UDF sets if R_EN=1. In FWFT mode the written word becomes visible on the next cycle.
  - When FULL: only the read is accepted; OVF sets if W_EN=1. The write is dropped and not retried.
- Error flags:
  - OVF <= 1 on W_EN & FULL. UDF <= 1 on R_EN & EMPTY.
  - ERR_CLR clears both flags. If ERR_CLR and a new error occur in the same cycle, set wins.
- Rejected accesses change neither pointers nor memory.
- Reset mid-operation: all state returns to reset values immediately. Previously stored data is discarded logically.

Decomposition:
- Shared package fifo_pkg holds:
  - clog2 function.
  - Pointer-width derivation (AW+1).
  - Elaboration-time DEPTH power-of-two check.
  - Threshold range checks: 0 <= AE_LEVEL < AF_LEVEL <= DEPTH.
- Sub-module: the existing fifo_memory array is reused as the storage instance. It gets a registered-read variant selected by FWFT. Pointer/flag logic stays in fifo_sync_ctrl.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F (no reads): FULL=1 after the 16th edge, COUNT=16, ALMOST_FULL asserted from COUNT=14. A 17th write sets OVF=1 and data is unchanged.
- Drain after fill (FWFT=1): R_DO reads 0x00..0x0F in order. EMPTY=1 after the 16th pop, ALMOST_EMPTY from COUNT=2. One further R_EN sets UDF=1.
- FWFT=0: write 0xA5, pulse R_EN: R_VALID=1 with R_DO=0xA5 exactly one cycle after the R_EN edge, then R_VALID=0.
- Simultaneous W_EN/R_EN every cycle for 40 cycles starting at COUNT=8: COUNT stays 8, data order is preserved across the pointer wrap (W_PTR passes 31→0).
- Write while EMPTY with R_EN=1: UDF=1 and COUNT=1. With ERR_CLR asserted the same cycle as a new overflow, OVF stays 1.
- Assert RSTN=0 mid-burst at COUNT=5: EMPTY=1, COUNT=0, R_VALID=0 and flags cleared immediately without a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared elaboration helpers for the synchronous FIFO family: address/pointer
// width derivation and parameter legality checks.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // One extra MSB distinguishes a full FIFO from an empty one.
    function automatic int ptr_width(input int aw);
        return aw + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit levels_ok(input int ae_level, input int af_level, input int depth);
        return (ae_level >= 0) && (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/fifo_memory.sv
// FIFO storage array: one write port, one read port that is either a
// combinational look-through or a registered read with one cycle of latency.
module fifo_memory #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int REG_READ = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; emptiness is tracked by the pointers, and a
    // resettable array would cost a reset fan-out to every storage bit.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    generate
        if (REG_READ != 0) begin : g_reg_read
            logic [WIDTH-1:0] rdata_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (re_i) begin
                    rdata_q <= mem_q[raddr_i];
                end
            end

            assign rdata_o = rdata_q;
        end else begin : g_comb_read
            logic unused_rst_n;
            assign unused_rst_n = rst_n;
            // Drive zero while nothing is stored so stale words never leak out.
            assign rdata_o = re_i ? mem_q[raddr_i] : '0;
        end
    endgenerate

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO: pointer control, fill level, almost flags, sticky
// overflow/underflow errors and a selectable FWFT or registered read port.
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AW       = clog2(DEPTH),
    parameter int FWFT     = 1,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             W_EN,
    input  logic [WIDTH-1:0] W_DI,
    input  logic             R_EN,
    output logic [WIDTH-1:0] R_DO,
    output logic             R_VALID,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY,
    output logic [AW:0]      COUNT,
    output logic             OVF,
    output logic             UDF,
    input  logic             ERR_CLR
);

    localparam int PW = ptr_width(AW);
    localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    generate
        if (!is_pow2(DEPTH)) begin : g_bad_depth
            $error("fifo_sync_ctrl: DEPTH must be a power of two and at least 2");
        end
        if (AW != clog2(DEPTH)) begin : g_bad_aw
            $error("fifo_sync_ctrl: AW must equal log2(DEPTH)");
        end
        if (!levels_ok(AE_LEVEL, AF_LEVEL, DEPTH)) begin : g_bad_levels
            $error("fifo_sync_ctrl: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate

    logic [PW-1:0] w_ptr_q, w_ptr_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          full, empty;
    logic          wr_ok, rd_ok;
    logic [PW-1:0] count;
    logic          mem_re;

    // Flags come only from registered pointers, never from W_EN/R_EN.
    assign full  = (w_ptr_q[AW] != r_ptr_q[AW]) && (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]);
    assign empty = (w_ptr_q == r_ptr_q);
    assign count = w_ptr_q - r_ptr_q;
    assign wr_ok = W_EN & ~full;
    assign rd_ok = R_EN & ~empty;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (wr_ok) begin
            w_ptr_d = w_ptr_q + PW'(1);
        end
        if (rd_ok) begin
            r_ptr_d = r_ptr_q + PW'(1);
        end
        if (ERR_CLR) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        // A new error in the same cycle as ERR_CLR must survive the clear.
        if (W_EN && full) begin
            ovf_d = 1'b1;
        end
        if (R_EN && empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign mem_re  = ~empty;
            assign R_VALID = ~empty;
        end else begin : g_registered
            logic rvalid_q;

            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_ok;
                end
            end

            assign mem_re  = rd_ok;
            assign R_VALID = rvalid_q;
        end
    endgenerate

    fifo_memory #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .REG_READ ((FWFT != 0) ? 0 : 1)
    ) u_mem (
        .clk     (CLK),
        .rst_n   (RSTN),
        .we_i    (wr_ok),
        .waddr_i (w_ptr_q[AW-1:0]),
        .wdata_i (W_DI),
        .re_i    (mem_re),
        .raddr_i (r_ptr_q[AW-1:0]),
        .rdata_o (R_DO)
    );

    assign FULL         = full;
    assign EMPTY        = empty;
    assign COUNT        = count;
    assign ALMOST_FULL  = (count >= AF_THR);
    assign ALMOST_EMPTY = (count <= AE_THR);
    assign OVF          = ovf_q;
    assign UDF          = udf_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Randomised bench for fifo_sync_ctrl: an FWFT and a registered-read instance
// share stimulus and are compared against a queue-based reference model.
module tb_fifo_sync_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic             CLK = 1'b0;
    logic             RSTN = 1'b0;
    logic             W_EN = 1'b0;
    logic [WIDTH-1:0] W_DI = '0;
    logic             R_EN = 1'b0;
    logic             ERR_CLR = 1'b0;

    logic [WIDTH-1:0] d1_rdo, d0_rdo;
    logic             d1_rvalid, d0_rvalid;
    logic             d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_udf;
    logic             d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf;
    logic [AW:0]      d1_count, d0_count;

    fifo_sync_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .FWFT(1),
                     .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_fwft (
        .CLK(CLK), .RSTN(RSTN), .W_EN(W_EN), .W_DI(W_DI), .R_EN(R_EN),
        .R_DO(d1_rdo), .R_VALID(d1_rvalid), .FULL(d1_full), .EMPTY(d1_empty),
        .ALMOST_FULL(d1_af), .ALMOST_EMPTY(d1_ae), .COUNT(d1_count),
        .OVF(d1_ovf), .UDF(d1_udf), .ERR_CLR(ERR_CLR)
    );

    fifo_sync_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .FWFT(0),
                     .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_reg (
        .CLK(CLK), .RSTN(RSTN), .W_EN(W_EN), .W_DI(W_DI), .R_EN(R_EN),
        .R_DO(d0_rdo), .R_VALID(d0_rvalid), .FULL(d0_full), .EMPTY(d0_empty),
        .ALMOST_FULL(d0_af), .ALMOST_EMPTY(d0_ae), .COUNT(d0_count),
        .OVF(d0_ovf), .UDF(d0_udf), .ERR_CLR(ERR_CLR)
    );

    always #5 CLK = ~CLK;

    wire [10:0] st1 = {d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_udf, d1_count};
    wire [10:0] st0 = {d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_udf, d0_count};

    // Reference model: stored words, sticky errors, registered-read output.
    logic [WIDTH-1:0] mq[$];
    bit               m_ovf, m_udf, m_rv0;
    logic [WIDTH-1:0] m_rdo0;

    int errors = 0;
    int checks = 0;

    function automatic logic [10:0] exp_status();
        int n;
        n = mq.size();
        return {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_udf, 5'(n)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_rv0  = 1'b0;
        m_rdo0 = '0;
    endtask

    // Drive one cycle of stimulus (called at posedge+1) and advance the model.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic clr);
        bit was_full, was_empty;
        W_EN = w; W_DI = d; R_EN = r; ERR_CLR = clr;
        @(posedge CLK);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        m_rv0 = 1'b0;
        if (r && !was_empty) begin
            m_rdo0 = mq.pop_front();
            m_rv0  = 1'b1;
        end
        if (w && !was_full) mq.push_back(d);
        if (clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (w && was_full)  m_ovf = 1'b1;
        if (r && was_empty) m_udf = 1'b1;
        #1;
        W_EN = 1'b0; R_EN = 1'b0; ERR_CLR = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        RSTN = 1'b0;
        #12;
        checks++;
        if (st1 !== 11'b01_01_00_00000) begin
            errors++; $display("FAIL reset_status_fwft: got %b expected %b", st1, 11'b01010000000);
        end
        checks++;
        if (st0 !== 11'b01_01_00_00000) begin
            errors++; $display("FAIL reset_status_reg: got %b expected %b", st0, 11'b01010000000);
        end
        checks++;
        if ({d1_rvalid, d0_rvalid, d1_rdo, d0_rdo} !== 18'd0) begin
            errors++; $display("FAIL reset_read_port: got rv=%b/%b rdo=%h/%h expected all zero",
                               d1_rvalid, d0_rvalid, d1_rdo, d0_rdo);
        end
        @(negedge CLK); RSTN = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if (st1 !== exp_status()) begin
                errors++; $display("FAIL fill_status[%0d]: got %b expected %b", i, st1, exp_status());
            end
            checks++;
            if (d1_af !== (i + 1 >= AF)) begin
                errors++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, d1_af, (i + 1 >= AF));
            end
        end
        checks++;
        if ({d1_full, d1_count} !== {1'b1, 5'd16}) begin
            errors++; $display("FAIL fill_full: got full=%b count=%0d expected 1/16", d1_full, d1_count);
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        checks++;
        if ({d1_ovf, d1_count, d1_rdo} !== {1'b1, 5'd16, 8'h00}) begin
            errors++; $display("FAIL overflow_write: got ovf=%b count=%0d head=%h expected 1/16/00",
                               d1_ovf, d1_count, d1_rdo);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if ({d1_rvalid, d1_rdo} !== {1'b1, 8'(i)}) begin
                errors++; $display("FAIL drain_fwft_head[%0d]: got v=%b %h expected 1 %h", i, d1_rvalid, d1_rdo, 8'(i));
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (st1 !== exp_status() || st0 !== exp_status()) begin
                errors++; $display("FAIL drain_status[%0d]: got %b/%b expected %b", i, st1, st0, exp_status());
            end
            checks++;
            if ({d0_rvalid, d0_rdo} !== {1'b1, 8'(i)}) begin
                errors++; $display("FAIL drain_reg_data[%0d]: got v=%b %h expected 1 %h", i, d0_rvalid, d0_rdo, 8'(i));
            end
        end
        checks++;
        if ({d1_empty, d1_ae, d1_rvalid} !== 3'b110) begin
            errors++; $display("FAIL drain_empty: got e/ae/v=%b%b%b expected 110", d1_empty, d1_ae, d1_rvalid);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({d1_udf, d0_udf, d0_rvalid, d1_count} !== {3'b110, 5'd0}) begin
            errors++; $display("FAIL underflow_read: got udf=%b/%b rv=%b count=%0d expected 1/1/0/0",
                               d1_udf, d0_udf, d0_rvalid, d1_count);
        end
    endtask

    task automatic test_err_clr();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if ({d1_ovf, d1_udf, d0_ovf, d0_udf} !== 4'b0000) begin
            errors++; $display("FAIL err_clr: got %b%b%b%b expected 0000", d1_ovf, d1_udf, d0_ovf, d0_udf);
        end
    endtask

    task automatic test_fwft0();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        checks++;
        if (d0_rvalid !== 1'b0) begin
            errors++; $display("FAIL reg_no_early_valid: got %b expected 0", d0_rvalid);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({d0_rvalid, d0_rdo} !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL reg_read_latency: got v=%b %h expected 1 a5", d0_rvalid, d0_rdo);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ({d0_rvalid, d0_rdo} !== {1'b0, 8'hA5}) begin
            errors++; $display("FAIL reg_valid_drop: got v=%b %h expected 0 a5", d0_rvalid, d0_rdo);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (d1_rdo !== mq[0]) begin
                errors++; $display("FAIL b2b_fwft_head[%0d]: got %h expected %h", i, d1_rdo, mq[0]);
            end
            step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
            checks++;
            if (d1_count !== 5'd8 || st0 !== exp_status()) begin
                errors++; $display("FAIL b2b_count[%0d]: got %0d/%b expected 8/%b", i, d1_count, st0, exp_status());
            end
            checks++;
            if ({d0_rvalid, d0_rdo} !== {1'b1, m_rdo0}) begin
                errors++; $display("FAIL b2b_reg_data[%0d]: got v=%b %h expected 1 %h", i, d0_rvalid, d0_rdo, m_rdo0);
            end
        end
    endtask

    task automatic test_empty_simul();
        for (int i = 0; i < 64 && mq.size() != 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        checks++;
        if ({d1_udf, d1_count, d1_rvalid, d1_rdo} !== {1'b1, 5'd1, 1'b1, 8'h5A}) begin
            errors++; $display("FAIL write_while_empty: got udf=%b count=%0d v=%b %h expected 1/1/1/5a",
                               d1_udf, d1_count, d1_rvalid, d1_rdo);
        end
        checks++;
        if (d0_rvalid !== 1'b0) begin
            errors++; $display("FAIL empty_read_rejected: got %b expected 0", d0_rvalid);
        end
    endtask

    task automatic test_ovf_clr();
        logic [WIDTH-1:0] head;
        for (int i = 0; i < 64 && mq.size() != DEPTH; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h11, 1'b0, 1'b1);
        checks++;
        if ({d1_ovf, d0_ovf, d1_count} !== {2'b11, 5'd16}) begin
            errors++; $display("FAIL ovf_set_beats_clr: got ovf=%b/%b count=%0d expected 1/1/16", d1_ovf, d0_ovf, d1_count);
        end
        step(1'b1, 8'h22, 1'b0, 1'b1);
        checks++;
        if (d1_ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_held_with_clr: got %b expected 1", d1_ovf);
        end
        head = mq[0];
        step(1'b1, 8'h33, 1'b1, 1'b0);
        checks++;
        if ({d1_count, d0_rvalid, d0_rdo, d1_ovf} !== {5'd15, 1'b1, head, 1'b1}) begin
            errors++; $display("FAIL rw_while_full: got count=%0d v=%b %h ovf=%b expected 15/1/%h/1",
                               d1_count, d0_rvalid, d0_rdo, d1_ovf, head);
        end
    endtask

    task automatic test_random();
        int pw;
        logic w, r, clr;
        for (int c = 0; c < 400; c++) begin
            pw  = ((c / 50) % 2 == 0) ? 70 : 30;
            w   = ($urandom_range(0, 99) < pw);
            r   = ($urandom_range(0, 99) < (100 - pw));
            clr = ($urandom_range(0, 15) == 0);
            step(w, 8'($urandom_range(0, 255)), r, clr);
            checks++;
            if (st1 !== exp_status() || st0 !== exp_status()) begin
                errors++; $display("FAIL rand_status[%0d]: got %b/%b expected %b", c, st1, st0, exp_status());
            end
            checks++;
            if (d1_rvalid !== (mq.size() != 0) || (mq.size() != 0 && d1_rdo !== mq[0])) begin
                errors++; $display("FAIL rand_fwft[%0d]: got v=%b %h expected v=%b", c, d1_rvalid, d1_rdo, (mq.size() != 0));
            end
            checks++;
            if (d0_rvalid !== m_rv0 || (m_rv0 && d0_rdo !== m_rdo0)) begin
                errors++; $display("FAIL rand_reg[%0d]: got v=%b %h expected v=%b %h", c, d0_rvalid, d0_rdo, m_rv0, m_rdo0);
            end
        end
    endtask

    task automatic test_reset_mid();
        RSTN = 1'b0; #3; RSTN = 1'b1;
        model_reset();
        @(posedge CLK); #1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'h46, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({d1_count, d1_udf, d0_rvalid} !== {5'd5, 1'b1, 1'b1}) begin
            errors++; $display("FAIL pre_reset_state: got count=%0d udf=%b v=%b expected 5/1/1", d1_count, d1_udf, d0_rvalid);
        end
        #2; RSTN = 1'b0; #1;
        model_reset();
        checks++;
        if (st1 !== 11'b01_01_00_00000 || st0 !== 11'b01_01_00_00000) begin
            errors++; $display("FAIL async_reset_status: got %b/%b expected 01010000000", st1, st0);
        end
        checks++;
        if ({d1_rvalid, d0_rvalid, d0_rdo} !== 10'd0) begin
            errors++; $display("FAIL async_reset_read: got v=%b/%b %h expected 0/0/00", d1_rvalid, d0_rvalid, d0_rdo);
        end
        @(negedge CLK); RSTN = 1'b1;
        @(posedge CLK); #1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        checks++;
        if ({d1_count, d1_rvalid, d1_rdo} !== {5'd1, 1'b1, 8'h3C}) begin
            errors++; $display("FAIL post_reset_write: got count=%0d v=%b %h expected 1/1/3c", d1_count, d1_rvalid, d1_rdo);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_err_clr();
        test_fwft0();
        test_back_to_back();
        test_empty_simul();
        test_ovf_clr();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
